// File: rtl/if_prefetch_pkg.sv
// rtl/if_prefetch_pkg.sv - shared widths, constants and the prefetch entry type
package if_prefetch_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;

  localparam logic [INST_BUS_W-1:0] INST_NOP  = 32'h0000_0001;
  localparam logic [INST_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic                  RST_ENABLE = 1'b0;

  typedef struct packed {
    logic [INST_ADDR_BUS_W-1:0] addr;
    logic [INST_BUS_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// rtl/if_prefetch_if.sv - instruction bus and decode-side handshake bundle
interface if_prefetch_if;
  import if_prefetch_pkg::*;

  logic                       ibus_req_o;
  logic [INST_ADDR_BUS_W-1:0] ibus_addr_o;
  logic                       ibus_gnt_i;
  logic                       ibus_rvalid_i;
  logic [INST_BUS_W-1:0]      ibus_rdata_i;
  logic                       inst_valid_o;
  logic [INST_BUS_W-1:0]      inst_o;
  logic [INST_ADDR_BUS_W-1:0] inst_addr_o;
  logic                       inst_ready_i;

  modport master (
    output ibus_req_o, ibus_addr_o,
    input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
    output inst_valid_o, inst_o, inst_addr_o,
    input  inst_ready_i
  );

  modport slave (
    input  ibus_req_o, ibus_addr_o,
    output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
    input  inst_valid_o, inst_o, inst_addr_o,
    output inst_ready_i
  );

endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - in-order prefetch buffer; a pop frees the slot for a same-cycle push
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty && !flush));
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - fetch stage: PC generation, pipelined ibus issue, prefetch buffer, jump flush
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_flag_i,
  input  logic [INST_ADDR_BUS_W-1:0] jump_addr_i,
  if_prefetch_if.master              bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [INST_ADDR_BUS_W-1:0] pc;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              outstanding_nxt;
  logic [CW-1:0]              discard;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       grant;
  logic                       accept;
  logic                       pop;
  fetch_entry_t               push_entry;
  fetch_entry_t               head;

  assign bus.ibus_req_o  = (rst != RST_ENABLE) && !jump_flag_i &&
                           (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_L);
  assign bus.ibus_addr_o = pc;
  assign grant           = bus.ibus_req_o && bus.ibus_gnt_i;

  // With nothing left to discard, every in-flight request was issued contiguously
  // since the last redirect, so the oldest one sits 4*outstanding below pc.
  assign accept          = bus.ibus_rvalid_i && (discard == '0) && !jump_flag_i;
  assign push_entry.addr = pc - {{(30-CW){1'b0}}, outstanding, 2'b00};
  assign push_entry.inst = bus.ibus_rdata_i;

  assign outstanding_nxt = outstanding + CW'(grant) - CW'(bus.ibus_rvalid_i);

  assign bus.inst_valid_o = !fifo_empty;
  assign bus.inst_o       = fifo_empty ? INST_NOP  : head.inst;
  assign bus.inst_addr_o  = fifo_empty ? ZERO_WORD : head.addr;
  assign pop              = bus.inst_valid_o && bus.inst_ready_i && !jump_flag_i;

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (push_entry),
    .pop   (pop),
    .flush (jump_flag_i),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      pc          <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (jump_flag_i) begin
        pc      <= jump_addr_i & 32'hFFFF_FFFC;
        discard <= outstanding_nxt;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (bus.ibus_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE) begin
      assert (!(bus.ibus_rvalid_i && (outstanding == '0)));
      assert (!(grant && (outstanding == DEPTH_C)));
      assert (!(accept && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed self-checking bench for if_prefetch
module tb_if_prefetch;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        resp_en;
  int          checks;
  int          failures;
  int          stray;
  int          model_out;
  int          grants;
  logic [31:0] rq[$];

  if_prefetch_if bus ();

  if_prefetch #(.RESET_ADDR(32'h0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_i (jump_flag),
    .jump_addr_i (jump_addr),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus model: grants sampled mid-cycle, in-order response one cycle later.
  always @(posedge clk) begin
    #1;
    if (rst && resp_en && rq.size() > 0) begin
      bus.ibus_rvalid_i = 1'b1;
      bus.ibus_rdata_i  = mem_word(rq.pop_front());
    end else begin
      bus.ibus_rvalid_i = 1'b0;
      bus.ibus_rdata_i  = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      rq.delete();
      model_out = 0;
    end else begin
      if (bus.ibus_rvalid_i) begin
        if (model_out == 0) stray++;
        else model_out--;
      end
      if (bus.ibus_req_o && bus.ibus_gnt_i) begin
        rq.push_back(bus.ibus_addr_o);
        model_out++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic g, input logic r, input logic e);
    rst              = 1'b0;
    jump_flag        = 1'b0;
    jump_addr        = 32'h0;
    bus.ibus_gnt_i   = g;
    bus.inst_ready_i = r;
    resp_en          = e;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget,
                            input logic [31:0] exp_addr, input logic [31:0] exp_inst);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk);
      if (bus.inst_valid_o) found = 1'b1;
      else begin
        n++;
        nxt();
      end
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      check({tag, "_addr"}, bus.inst_addr_o, exp_addr);
      check({tag, "_inst"}, bus.inst_o, exp_inst);
    end
  endtask

  initial begin
    checks = 0; failures = 0; stray = 0; model_out = 0;
    rst = 1'b0; jump_flag = 1'b0; jump_addr = 32'h0; resp_en = 1'b1;
    bus.ibus_gnt_i = 1'b1; bus.inst_ready_i = 1'b1;
    bus.ibus_rvalid_i = 1'b0; bus.ibus_rdata_i = 32'h0;

    // Reset state, then streaming from 0x0
    @(negedge clk);
    check("rst_req", 32'(bus.ibus_req_o), 32'd0);
    check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst_inst", bus.inst_o, 32'h0000_0001);
    check("rst_addr", bus.inst_addr_o, 32'h0);
    do_reset(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("s_c0_req", 32'(bus.ibus_req_o), 32'd1);
    check("s_c0_addr", bus.ibus_addr_o, 32'h0);
    check("s_c0_valid", 32'(bus.inst_valid_o), 32'd0);
    nxt(); @(negedge clk);
    check("s_c1_addr", bus.ibus_addr_o, 32'h4);
    check("s_c1_valid", 32'(bus.inst_valid_o), 32'd0);
    nxt(); @(negedge clk);
    check("s_c2_valid", 32'(bus.inst_valid_o), 32'd1);
    check("s_c2_iaddr", bus.inst_addr_o, 32'h0);
    check("s_c2_inst", bus.inst_o, 32'h0000_0013);
    nxt(); @(negedge clk);
    check("s_c3_iaddr", bus.inst_addr_o, 32'h4);
    check("s_c3_inst", bus.inst_o, 32'h0000_0017);
    nxt();
    wait_valid("s_third", 4, 32'h8, 32'h0000_001B);

    // Hold: decode stalls, issue stops at DEPTH
    do_reset(1'b1, 1'b0, 1'b1);
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ibus_req_o && bus.ibus_gnt_i) grants++;
      if (i < 4) nxt();
    end
    check("hold_grants", 32'(grants), 32'd2);
    check("hold_req", 32'(bus.ibus_req_o), 32'd0);
    check("hold_valid", 32'(bus.inst_valid_o), 32'd1);
    check("hold_head", bus.inst_addr_o, 32'h0);
    nxt(); bus.inst_ready_i = 1'b1;
    @(negedge clk);
    check("hold_pop0", bus.inst_addr_o, 32'h0);
    nxt(); @(negedge clk);
    check("hold_pop1_v", 32'(bus.inst_valid_o), 32'd1);
    check("hold_pop1", bus.inst_addr_o, 32'h4);

    // Grant withheld for 3 cycles
    do_reset(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gw_req", 32'(bus.ibus_req_o), 32'd1);
      check("gw_addr", bus.ibus_addr_o, 32'h0);
      nxt();
    end
    bus.ibus_gnt_i = 1'b1;
    @(negedge clk);
    check("gw_gnt_addr", bus.ibus_addr_o, 32'h0);
    nxt(); @(negedge clk);
    check("gw_next_addr", bus.ibus_addr_o, 32'h4);

    // Back-to-back jumps with two requests in flight
    do_reset(1'b1, 1'b1, 1'b0);
    nxt(); nxt();
    jump_flag = 1'b1; jump_addr = 32'h100; resp_en = 1'b1;
    @(negedge clk);
    check("j1_req", 32'(bus.ibus_req_o), 32'd0);
    nxt(); jump_addr = 32'h180;
    @(negedge clk);
    check("j1_next_valid", 32'(bus.inst_valid_o), 32'd0);
    nxt(); jump_flag = 1'b0;
    @(negedge clk);
    check("j2_next_req", 32'(bus.ibus_req_o), 32'd1);
    check("j2_next_addr", bus.ibus_addr_o, 32'h180);
    check("j2_next_valid", 32'(bus.inst_valid_o), 32'd0);
    nxt();
    wait_valid("j2_first", 6, 32'h180, 32'h0000_0193);

    // Jump coinciding with an rvalid
    do_reset(1'b1, 1'b1, 1'b1);
    nxt(); jump_flag = 1'b1; jump_addr = 32'h300;
    @(negedge clk);
    check("jr_req", 32'(bus.ibus_req_o), 32'd0);
    nxt(); jump_flag = 1'b0;
    @(negedge clk);
    check("jr_next_valid", 32'(bus.inst_valid_o), 32'd0);
    check("jr_next_req", 32'(bus.ibus_req_o), 32'd1);
    check("jr_next_addr", bus.ibus_addr_o, 32'h300);
    nxt();
    wait_valid("jr_first", 4, 32'h300, 32'h0000_0313);

    // Jump to unaligned target with a full FIFO and a pop attempt in J
    do_reset(1'b1, 1'b0, 1'b1);
    nxt(); nxt(); nxt();
    jump_flag = 1'b1; jump_addr = 32'h203; bus.inst_ready_i = 1'b1;
    @(negedge clk);
    check("ju_j_valid", 32'(bus.inst_valid_o), 32'd1);
    nxt(); jump_flag = 1'b0; bus.inst_ready_i = 1'b0;
    @(negedge clk);
    check("ju_next_valid", 32'(bus.inst_valid_o), 32'd0);
    check("ju_next_req", 32'(bus.ibus_req_o), 32'd1);
    check("ju_next_addr", bus.ibus_addr_o, 32'h200);
    nxt();
    wait_valid("ju_first", 4, 32'h200, 32'h0000_0213);

    // Reset mid-stream with two requests in flight
    do_reset(1'b1, 1'b1, 1'b0);
    nxt(); nxt();
    rst = 1'b0; resp_en = 1'b1;
    #1;
    check("mr_req", 32'(bus.ibus_req_o), 32'd0);
    check("mr_valid", 32'(bus.inst_valid_o), 32'd0);
    check("mr_inst", bus.inst_o, 32'h0000_0001);
    check("mr_addr", bus.inst_addr_o, 32'h0);
    @(negedge clk);
    nxt(); rst = 1'b1;
    wait_valid("mr_restart", 6, 32'h0, 32'h0000_0013);

    check("bus_no_stray_rvalid", 32'(stray), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
